// File: rtl/wb_scoreboard_if.sv
// ---------------------------------------------------------------------------
// wb_scoreboard_if
// Bundles every pipeline-side signal of the register-write scoreboard.
//   D stage  : IssueD, RdD, RegWriteD, FRegWriteD, Rs1D..Rs3D, Use1D..Use3D,
//              Fp1D..Fp3D (pipeline -> scoreboard)
//   E stage  : FlushE, RdE, RegWriteE, FRegWriteE (pipeline -> scoreboard)
//   W stage  : RdW, RegWriteW, FRegWriteW (pipeline -> scoreboard)
//   Status   : StallD, Busy, Underflow, Cleaning (scoreboard -> pipeline)
// modport master : the pipeline / hazard-unit side that drives the stages.
// modport slave  : the scoreboard itself.
// ---------------------------------------------------------------------------
interface wb_scoreboard_if;
  logic       IssueD;
  logic [4:0] RdD;
  logic       RegWriteD;
  logic       FRegWriteD;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs3D;
  logic       Use1D;
  logic       Use2D;
  logic       Use3D;
  logic       Fp1D;
  logic       Fp2D;
  logic       Fp3D;
  logic       FlushE;
  logic [4:0] RdE;
  logic       RegWriteE;
  logic       FRegWriteE;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic       FRegWriteW;
  logic       StallD;
  logic       Busy;
  logic       Underflow;
  logic       Cleaning;

  modport master (
    output IssueD, RdD, RegWriteD, FRegWriteD,
    output Rs1D, Rs2D, Rs3D, Use1D, Use2D, Use3D, Fp1D, Fp2D, Fp3D,
    output FlushE, RdE, RegWriteE, FRegWriteE,
    output RdW, RegWriteW, FRegWriteW,
    input  StallD, Busy, Underflow, Cleaning
  );

  modport slave (
    input  IssueD, RdD, RegWriteD, FRegWriteD,
    input  Rs1D, Rs2D, Rs3D, Use1D, Use2D, Use3D, Fp1D, Fp2D, Fp3D,
    input  FlushE, RdE, RegWriteE, FRegWriteE,
    input  RdW, RegWriteW, FRegWriteW,
    output StallD, Busy, Underflow, Cleaning
  );
endinterface

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Tracks in-flight integer and FP register writes between issue (D) and
// write-back (W) with one 2-bit pending counter per architectural register,
// and derives the decode RAW/WAW interlock from those counters.
// Ports:
//   clk   : pipeline clock, all state updates on posedge
//   reset : synchronous, active-high; followed by one cleanup cycle
//   bus   : wb_scoreboard_if.slave -- D/E/W stage inputs and the
//           StallD / Busy / Underflow / Cleaning status outputs
// ---------------------------------------------------------------------------
module wb_scoreboard (
  input logic            clk,
  input logic            reset,
  wb_scoreboard_if.slave bus
);

  // Pending-write counters; int x0 is held at zero permanently.
  logic [1:0] int_cnt_r     [32];
  logic [1:0] fp_cnt_r      [32];
  logic [1:0] int_cnt_nxt_s [32];
  logic [1:0] fp_cnt_nxt_s  [32];

  logic       cleaning_r;
  logic       busy_r;
  logic       underflow_r;

  logic [4:0] rs_s [3];
  logic [2:0] use_s;
  logic [2:0] fp_s;
  logic       raw_s;
  logic       waw_s;
  logic       stall_s;
  logic       issue_ok_s;
  logic       evt_en_s;
  logic       flush_int_s;
  logic       flush_fp_s;
  logic       uf_hit_s;
  logic       busy_nxt_s;

  // A source still waits if its effective count (stored count minus a
  // same-cycle W retire of that register) is above zero. The register file
  // writes on negedge, so D sees the value retired this cycle.
  function automatic logic src_pending(input logic [1:0] cnt, input logic retire_hit);
    src_pending = (cnt > 2'd1) || ((cnt == 2'd1) && !retire_hit);
  endfunction

  // Net counter update for one cycle: +inc, -dec_a, -dec_b, clamped at zero.
  // Bit 2 of the result flags that some decrement found nothing to retire.
  function automatic logic [2:0] net_update(input logic [1:0] cnt, input logic inc,
                                            input logic dec_a, input logic dec_b);
    logic [2:0] up;
    logic [2:0] dn;
    logic [2:0] diff;
    up   = {1'b0, cnt} + {2'b00, inc};
    dn   = {2'b00, dec_a} + {2'b00, dec_b};
    diff = up - dn;
    if (up < dn) begin
      net_update = {1'b1, 2'b00};
    end else begin
      net_update = {1'b0, diff[1:0]};
    end
  endfunction

  assign rs_s[0] = bus.Rs1D;
  assign rs_s[1] = bus.Rs2D;
  assign rs_s[2] = bus.Rs3D;
  assign use_s   = {bus.Use3D, bus.Use2D, bus.Use1D};
  assign fp_s    = {bus.Fp3D, bus.Fp2D, bus.Fp1D};

  // RAW check of every used source against its own register file.
  always_comb begin
    raw_s = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (!use_s[n]) begin
        raw_s = raw_s;
      end else if (fp_s[n]) begin
        raw_s = raw_s | src_pending(fp_cnt_r[rs_s[n]],
                                    bus.FRegWriteW && (bus.RdW == rs_s[n]));
      end else begin
        raw_s = raw_s | src_pending(int_cnt_r[rs_s[n]],
                                    bus.RegWriteW && (bus.RdW == rs_s[n]));
      end
    end
  end

  // A fourth write to one register would overflow its 2-bit counter.
  assign waw_s = (bus.RegWriteD  && (int_cnt_r[bus.RdD] == 2'd3)) ||
                 (bus.FRegWriteD && (fp_cnt_r[bus.RdD]  == 2'd3));

  assign stall_s     = cleaning_r | raw_s | waw_s;
  assign issue_ok_s  = bus.IssueD & ~stall_s;
  // Decrements are frozen during the cleanup cycle; increments already are
  // because StallD is forced high then.
  assign evt_en_s    = ~cleaning_r;
  assign flush_int_s = evt_en_s & bus.FlushE & bus.RegWriteE;
  assign flush_fp_s  = evt_en_s & bus.FlushE & bus.FRegWriteE;

  // Per-register next counts, underflow detection and next Busy.
  always_comb begin
    logic [2:0] upd_int;
    logic [2:0] upd_fp;
    upd_int    = 3'b000;
    upd_fp     = 3'b000;
    uf_hit_s   = 1'b0;
    busy_nxt_s = 1'b0;
    for (int i = 0; i < 32; i++) begin
      upd_int = net_update(int_cnt_r[i],
                           issue_ok_s && bus.RegWriteD && (bus.RdD == 5'(i)),
                           evt_en_s && bus.RegWriteW && (bus.RdW == 5'(i)),
                           flush_int_s && (bus.RdE == 5'(i)));
      upd_fp  = net_update(fp_cnt_r[i],
                           issue_ok_s && bus.FRegWriteD && (bus.RdD == 5'(i)),
                           evt_en_s && bus.FRegWriteW && (bus.RdW == 5'(i)),
                           flush_fp_s && (bus.RdE == 5'(i)));
      if (i == 0) begin
        int_cnt_nxt_s[i] = 2'd0;
      end else begin
        int_cnt_nxt_s[i] = upd_int[1:0];
        uf_hit_s         = uf_hit_s | upd_int[2];
      end
      fp_cnt_nxt_s[i] = upd_fp[1:0];
      uf_hit_s        = uf_hit_s | upd_fp[2];
      busy_nxt_s      = busy_nxt_s | (int_cnt_nxt_s[i] != 2'd0) | (fp_cnt_nxt_s[i] != 2'd0);
    end
  end

  // Counter, cleanup, Busy and sticky Underflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        int_cnt_r[i] <= 2'd0;
        fp_cnt_r[i]  <= 2'd0;
      end
      cleaning_r  <= 1'b1;
      busy_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        int_cnt_r[i] <= int_cnt_nxt_s[i];
        fp_cnt_r[i]  <= fp_cnt_nxt_s[i];
      end
      cleaning_r  <= 1'b0;
      busy_r      <= busy_nxt_s;
      underflow_r <= underflow_r | uf_hit_s;
    end
  end

  assign bus.StallD    = stall_s;
  assign bus.Busy      = busy_r;
  assign bus.Underflow = underflow_r;
  assign bus.Cleaning  = cleaning_r;

endmodule

// File: tb/tb_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_wb_scoreboard
// Scoreboard bench: every driven cycle pushes the reference model's expected
// StallD/Busy/Underflow/Cleaning into a queue; an independent monitor pops
// and compares mid-cycle. Directed scenarios are followed by randomized
// traffic from a small E/M/W pipeline model with random flushes.
// ---------------------------------------------------------------------------
module tb_wb_scoreboard;

  typedef struct packed {
    logic            reset;
    logic            issue;
    logic            rw_d;
    logic            fw_d;
    logic [4:0]      rd_d;
    logic [2:0][4:0] rs;
    logic [2:0]      use_v;
    logic [2:0]      fp_v;
    logic            flush;
    logic            rw_e;
    logic            fw_e;
    logic [4:0]      rd_e;
    logic            rw_w;
    logic            fw_w;
    logic [4:0]      rd_w;
  } stim_t;

  typedef struct packed {
    logic stall;
    logic busy;
    logic uf;
    logic cln;
    int   cyc;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic       iw;
    logic       fw;
    logic [4:0] rd;
  } slot_t;

  logic clk;
  logic reset;
  wb_scoreboard_if sb_if ();

  wb_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: pending write counts per register, plus status flags.
  int   m_int [32];
  int   m_fp  [32];
  logic m_cln;
  logic m_busy;
  logic m_uf;

  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Spec rule: stall if cleaning, any used source still pending after the
  // same-cycle W credit, or the destination already has three writes pending.
  function automatic logic model_stall(input stim_t s);
    int c;
    int ret;
    logic st;
    st = m_cln;
    for (int n = 0; n < 3; n++) begin
      if (s.use_v[n]) begin
        if (s.fp_v[n]) begin
          c   = m_fp[s.rs[n]];
          ret = (s.fw_w && s.rd_w == s.rs[n]) ? 1 : 0;
        end else begin
          c   = (s.rs[n] == 5'd0) ? 0 : m_int[s.rs[n]];
          ret = (s.rw_w && s.rd_w == s.rs[n]) ? 1 : 0;
        end
        if (c - ret > 0) st = 1'b1;
      end
    end
    if (s.rw_d && s.rd_d != 5'd0 && m_int[s.rd_d] == 3) st = 1'b1;
    if (s.fw_d && m_fp[s.rd_d] == 3) st = 1'b1;
    return st;
  endfunction

  function automatic void model_update(input stim_t s, input logic st);
    int v;
    if (s.reset) begin
      for (int r = 0; r < 32; r++) begin
        m_int[r] = 0;
        m_fp[r]  = 0;
      end
      m_cln = 1'b1; m_busy = 1'b0; m_uf = 1'b0;
      return;
    end
    if (!m_cln) begin
      for (int r = 1; r < 32; r++) begin
        v = m_int[r];
        if (s.issue && !st && s.rw_d && s.rd_d == r) v++;
        if (s.rw_w && s.rd_w == r) v--;
        if (s.flush && s.rw_e && s.rd_e == r) v--;
        if (v < 0) begin m_uf = 1'b1; v = 0; end
        m_int[r] = v;
      end
      for (int r = 0; r < 32; r++) begin
        v = m_fp[r];
        if (s.issue && !st && s.fw_d && s.rd_d == r) v++;
        if (s.fw_w && s.rd_w == r) v--;
        if (s.flush && s.fw_e && s.rd_e == r) v--;
        if (v < 0) begin m_uf = 1'b1; v = 0; end
        m_fp[r] = v;
      end
    end
    m_cln  = 1'b0;
    m_busy = 1'b0;
    for (int r = 0; r < 32; r++) begin
      if (m_int[r] != 0 || m_fp[r] != 0) m_busy = 1'b1;
    end
  endfunction

  // Drive one cycle on the negedge and enqueue what the model expects.
  task automatic step(input stim_t s, output logic st);
    exp_t e;
    @(negedge clk);
    reset            = s.reset;
    sb_if.IssueD     = s.issue;
    sb_if.RegWriteD  = s.rw_d;
    sb_if.FRegWriteD = s.fw_d;
    sb_if.RdD        = s.rd_d;
    sb_if.Rs1D       = s.rs[0];
    sb_if.Rs2D       = s.rs[1];
    sb_if.Rs3D       = s.rs[2];
    sb_if.Use1D      = s.use_v[0];
    sb_if.Use2D      = s.use_v[1];
    sb_if.Use3D      = s.use_v[2];
    sb_if.Fp1D       = s.fp_v[0];
    sb_if.Fp2D       = s.fp_v[1];
    sb_if.Fp3D       = s.fp_v[2];
    sb_if.FlushE     = s.flush;
    sb_if.RegWriteE  = s.rw_e;
    sb_if.FRegWriteE = s.fw_e;
    sb_if.RdE        = s.rd_e;
    sb_if.RegWriteW  = s.rw_w;
    sb_if.FRegWriteW = s.fw_w;
    sb_if.RdW        = s.rd_w;
    st     = model_stall(s);
    e.stall = st;
    e.busy  = m_busy;
    e.uf    = m_uf;
    e.cln   = m_cln;
    e.cyc   = cyc_no;
    cyc_no++;
    exp_q.push_back(e);
    model_update(s, st);
  endtask

  task automatic check_bit(input string name, input int cyc, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_bit("StallD",    e.cyc, sb_if.StallD,    e.stall);
        check_bit("Busy",      e.cyc, sb_if.Busy,      e.busy);
        check_bit("Underflow", e.cyc, sb_if.Underflow, e.uf);
        check_bit("Cleaning",  e.cyc, sb_if.Cleaning,  e.cln);
      end
    end
  end

  initial begin
    stim_t s;
    logic  st;
    slot_t e_sl, m_sl, w_sl;
    logic  acc;

    for (int r = 0; r < 32; r++) begin
      m_int[r] = 0;
      m_fp[r]  = 0;
    end
    m_cln = 1'b1; m_busy = 1'b0; m_uf = 1'b0;
    s = idle();
    reset = 1'b1;
    {sb_if.IssueD, sb_if.RegWriteD, sb_if.FRegWriteD, sb_if.RdD} = '0;
    {sb_if.Rs1D, sb_if.Rs2D, sb_if.Rs3D} = '0;
    {sb_if.Use1D, sb_if.Use2D, sb_if.Use3D, sb_if.Fp1D, sb_if.Fp2D, sb_if.Fp3D} = '0;
    {sb_if.FlushE, sb_if.RegWriteE, sb_if.FRegWriteE, sb_if.RdE} = '0;
    {sb_if.RegWriteW, sb_if.FRegWriteW, sb_if.RdW} = '0;
    @(posedge clk);

    // Reset held two cycles, then cleanup with an issue that must be ignored.
    s = idle(); s.reset = 1'b1;
    step(s, st); step(s, st);
    s = idle(); s.issue = 1'b1; s.rw_d = 1'b1; s.rd_d = 5'd3;
    step(s, st);
    s = idle(); s.rs[0] = 5'd3; s.use_v = 3'b001;
    step(s, st); step(s, st);

    // RAW across the pipeline on x5 with same-cycle retire credit.
    s = idle(); s.issue = 1'b1; s.rw_d = 1'b1; s.rd_d = 5'd5;
    step(s, st);
    s = idle(); s.issue = 1'b1; s.rs[0] = 5'd5; s.use_v = 3'b001;
    step(s, st); step(s, st);
    s.rw_w = 1'b1; s.rd_w = 5'd5;
    step(s, st);
    s.rw_w = 1'b0;
    step(s, st);

    // File separation: f5 pending must not block a read of x5.
    s = idle(); s.issue = 1'b1; s.fw_d = 1'b1; s.rd_d = 5'd5;
    step(s, st);
    s = idle(); s.rs[1] = 5'd5; s.use_v = 3'b010;
    step(s, st);
    s.fp_v = 3'b010;
    step(s, st);
    s = idle(); s.fw_w = 1'b1; s.rd_w = 5'd5;
    step(s, st);

    // x0 writes are not tracked.
    s = idle(); s.issue = 1'b1; s.rw_d = 1'b1; s.rd_d = 5'd0;
    step(s, st); step(s, st); step(s, st);
    s = idle(); s.rs[2] = 5'd0; s.use_v = 3'b100;
    step(s, st);

    // f7 saturation: fourth issue stalls and is dropped.
    s = idle(); s.issue = 1'b1; s.fw_d = 1'b1; s.rd_d = 5'd7;
    for (int k = 0; k < 4; k++) step(s, st);
    s = idle(); s.fw_w = 1'b1; s.rd_w = 5'd7;
    for (int k = 0; k < 3; k++) step(s, st);
    s = idle(); s.rs[0] = 5'd7; s.fp_v = 3'b001; s.use_v = 3'b001;
    step(s, st);

    // Simultaneous issue, retire and flush on x9 with two pending.
    s = idle(); s.issue = 1'b1; s.rw_d = 1'b1; s.rd_d = 5'd9;
    step(s, st); step(s, st);
    s.rw_w = 1'b1; s.rd_w = 5'd9; s.flush = 1'b1; s.rw_e = 1'b1; s.rd_e = 5'd9;
    step(s, st);
    s = idle(); s.rs[0] = 5'd9; s.use_v = 3'b001;
    step(s, st);
    s.rw_w = 1'b1; s.rd_w = 5'd9;
    step(s, st);
    s.rw_w = 1'b0;
    step(s, st);

    // Underflow on an idle x12 is sticky.
    s = idle(); s.rw_w = 1'b1; s.rd_w = 5'd12;
    step(s, st);
    s = idle(); s.rs[0] = 5'd12; s.use_v = 3'b001;
    step(s, st); step(s, st); step(s, st);
    s = idle(); s.reset = 1'b1;
    step(s, st);

    // Randomized traffic through an E/M/W pipeline with flushes and a reset.
    e_sl = '0; m_sl = '0; w_sl = '0;
    for (int k = 0; k < 400; k++) begin
      s = idle();
      if (k == 200 || k == 201) s.reset = 1'b1;
      s.issue = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       begin s.rw_d = 1'b0; s.fw_d = 1'b0; end
        1:       begin s.rw_d = 1'b1; s.fw_d = 1'b0; end
        default: begin s.rw_d = 1'b0; s.fw_d = 1'b1; end
      endcase
      s.rd_d = 5'($urandom_range(0, 7));
      for (int n = 0; n < 3; n++) s.rs[n] = 5'($urandom_range(0, 7));
      s.use_v = 3'($urandom_range(0, 7));
      s.fp_v  = 3'($urandom_range(0, 7));
      s.rw_e  = e_sl.v & e_sl.iw;
      s.fw_e  = e_sl.v & e_sl.fw;
      s.rd_e  = e_sl.rd;
      s.flush = e_sl.v && ($urandom_range(0, 7) == 0);
      s.rw_w  = w_sl.v & w_sl.iw;
      s.fw_w  = w_sl.v & w_sl.fw;
      s.rd_w  = w_sl.rd;
      step(s, st);
      acc  = s.issue && !st && (s.rw_d || s.fw_d) && !s.reset;
      w_sl = m_sl;
      m_sl = s.flush ? slot_t'('0) : e_sl;
      e_sl = acc ? slot_t'({1'b1, s.rw_d, s.fw_d, s.rd_d}) : slot_t'('0);
      if (s.reset) begin
        e_sl = '0; m_sl = '0; w_sl = '0;
      end
    end

    // Drain the pipeline so Busy must return to zero.
    for (int k = 0; k < 4; k++) begin
      s = idle();
      s.rw_w = w_sl.v & w_sl.iw;
      s.fw_w = w_sl.v & w_sl.fw;
      s.rd_w = w_sl.rd;
      s.rw_e = e_sl.v & e_sl.iw;
      s.fw_e = e_sl.v & e_sl.fw;
      s.rd_e = e_sl.rd;
      step(s, st);
      w_sl = m_sl; m_sl = e_sl; e_sl = '0;
    end

    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
